vscale_sim_top: RTL and testbench

VSCALE_SIM_TOP -- requirements
Module: vscale_sim_top

---
 rtl/vscale_sim_top.sv | 253 +++++++++++++++++++++++++
 tb/tb_vscale_sim_top.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_sim_top.sv
// vscale_sim_top: two-cycle RV32I core with 128 KiB word memory and an HTIF tohost port.
// Optional per-instruction trace is compiled in when VSCALE_TRACE_EN is defined.

module vscale_hasti_mem (
  input  logic        clk,
  input  logic [14:0] addr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [31:0] wdata
);
  // NOTE: the array has no reset; its contents come from backdoor loads or stores.
  logic [31:0] mem [0:32767];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

module vscale_sim_top #(
  parameter int          HTIF_PCR_WIDTH   = 64,
  parameter logic [11:0] CSR_ADDR_TO_HOST = 12'h780,
  parameter logic [31:0] RESET_PC         = 32'h200
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      htif_pcr_req_valid,
  output logic                      htif_pcr_req_ready,
  input  logic                      htif_pcr_req_rw,
  input  logic [11:0]               htif_pcr_req_addr,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  output logic                      htif_pcr_resp_valid,
  input  logic                      htif_pcr_resp_ready,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  localparam logic [6:0] OP_LUI    = 7'h37, OP_AUIPC = 7'h17, OP_JAL    = 7'h6f,
                         OP_JALR   = 7'h67, OP_BRANCH = 7'h63, OP_LOAD  = 7'h03,
                         OP_STORE  = 7'h23, OP_IMM   = 7'h13, OP_OP     = 7'h33,
                         OP_FENCE  = 7'h0f, OP_SYSTEM = 7'h73;

  state_t      state, state_next;
  logic [31:0] pc, pc_next, ir, tohost;
  logic [31:0] regs [0:31];

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, eff_addr, mem_rdata;
  logic [14:0] mem_addr;
  logic        mem_we;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  // One memory port: instruction fetch in FETCH, load/store address in EXEC.
  assign eff_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign mem_addr = (state == FETCH) ? pc[16:2] : eff_addr[16:2];

  vscale_hasti_mem hasti_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .rdata (mem_rdata),
    .we    (mem_we),
    .wdata (rs2_val)
  );

  logic [31:0]        alu_b, alu_out, sra_out;
  logic [4:0]         shamt;
  logic               br_taken;

  assign alu_b   = (opcode == OP_OP) ? rs2_val : imm_i;
  assign shamt   = alu_b[4:0];
  assign sra_out = $signed(rs1_val) >>> shamt;

  always_comb begin
    case (funct3)
      3'b000:  alu_out = (opcode == OP_OP && funct7[5]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001:  alu_out = rs1_val << shamt;
      3'b010:  alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_out = {31'd0, rs1_val < alu_b};
      3'b100:  alu_out = rs1_val ^ alu_b;
      3'b101:  alu_out = funct7[5] ? sra_out : rs1_val >> shamt;
      3'b110:  alu_out = rs1_val | alu_b;
      default: alu_out = rs1_val & alu_b;
    endcase
    case (funct3)
      3'b000:  br_taken = rs1_val == rs2_val;
      3'b001:  br_taken = rs1_val != rs2_val;
      3'b100:  br_taken = $signed(rs1_val) <  $signed(rs2_val);
      3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_taken = rs1_val <  rs2_val;
      default: br_taken = rs1_val >= rs2_val;
    endcase
  end

  // Only tohost exists; every other CSR address reads as zero and drops writes.
  logic        csr_hit;
  logic [31:0] csr_old, csr_src, csr_new;
  assign csr_hit = ir[31:20] == CSR_ADDR_TO_HOST;
  assign csr_old = csr_hit ? tohost : 32'd0;
  assign csr_src = funct3[2] ? {27'd0, rs1} : rs1_val;

  always_comb begin
    case (funct3[1:0])
      2'b01:   csr_new = csr_src;
      2'b10:   csr_new = csr_old | csr_src;
      default: csr_new = csr_old & ~csr_src;
    endcase
  end

  logic        rd_we, illegal, core_tohost_we;
  logic [31:0] rd_wdata, core_tohost_wdata;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next        = state;
    pc_next           = pc;
    rd_we             = 1'b0;
    rd_wdata          = alu_out;
    mem_we            = 1'b0;
    illegal           = 1'b0;
    core_tohost_we    = 1'b0;
    core_tohost_wdata = csr_new;
    case (state)
      FETCH: state_next = EXEC;
      EXEC: begin
        state_next = FETCH;
        pc_next    = pc + 32'd4;
        case (opcode)
          OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
          OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc + imm_u; end
          OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc + 32'd4; pc_next = pc + imm_j; end
          OP_JALR: begin
            illegal  = funct3 != 3'b000;
            rd_we    = 1'b1;
            rd_wdata = pc + 32'd4;
            pc_next  = (rs1_val + imm_i) & ~32'd1;
          end
          OP_BRANCH: begin
            illegal = funct3[2:1] == 2'b01;
            if (br_taken) pc_next = pc + imm_b;
          end
          OP_LOAD: begin
            illegal  = funct3 != 3'b010 || eff_addr[1:0] != 2'b00;
            rd_we    = 1'b1;
            rd_wdata = mem_rdata;
          end
          // Store enable is qualified by reset so a reset edge never lands a write.
          OP_STORE: begin
            illegal = funct3 != 3'b010 || eff_addr[1:0] != 2'b00;
            mem_we  = reset;
          end
          OP_IMM: begin
            illegal = (funct3 == 3'b001 && funct7 != 7'h00) ||
                      (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
            rd_we   = 1'b1;
          end
          OP_OP: begin
            illegal = !(funct7 == 7'h00 ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
            rd_we   = 1'b1;
          end
          OP_FENCE: illegal = funct3 != 3'b000;
          OP_SYSTEM: begin
            illegal        = funct3[1:0] == 2'b00;
            rd_we          = 1'b1;
            rd_wdata       = csr_old;
            core_tohost_we = csr_hit;
          end
          default: illegal = 1'b1;
        endcase
        if (illegal) begin
          state_next        = HALT;
          pc_next           = pc;
          rd_we             = 1'b0;
          mem_we            = 1'b0;
          core_tohost_we    = 1'b1;
          core_tohost_wdata = 32'h0000FFFF;
        end
      end
      default: state_next = HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
      ir <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (state == FETCH) ir <= mem_rdata;
      if (rd_we && rd != 5'd0) regs[rd] <= rd_wdata;
    end
  end

  logic req_fire, htif_hit;
  assign htif_pcr_req_ready = !htif_pcr_resp_valid || !reset;
  assign req_fire           = htif_pcr_req_valid && htif_pcr_req_ready;
  assign htif_hit           = htif_pcr_req_addr == CSR_ADDR_TO_HOST;

  // HTIF write is applied after the core write so it wins on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tohost              <= '0;
      htif_pcr_resp_valid <= 1'b0;
      htif_pcr_resp_data  <= '0;
    end else begin
      if (core_tohost_we) tohost <= core_tohost_wdata;
      if (req_fire) begin
        htif_pcr_resp_valid <= 1'b1;
        htif_pcr_resp_data  <= (!htif_pcr_req_rw && htif_hit) ?
                               {{(HTIF_PCR_WIDTH-32){1'b0}}, tohost} : '0;
        if (htif_pcr_req_rw && htif_hit) tohost <= htif_pcr_req_data[31:0];
      end else if (htif_pcr_resp_valid && htif_pcr_resp_ready) begin
        htif_pcr_resp_valid <= 1'b0;
        htif_pcr_resp_data  <= '0;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{htif_pcr_req_data[HTIF_PCR_WIDTH-1:32], eff_addr[31:17]};

`ifdef VSCALE_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && state == EXEC) $display("pc=%h instr=%h", pc, ir);
  end
`endif
endmodule

// File: tb/tb_vscale_sim_top.sv
// Self-checking bench for vscale_sim_top: ALU vector table run as tiny programs,
// plus hand sequences for HTIF handshake, halt, branches, CSR and reset corners.
module tb_vscale_sim_top;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, LOAD = 7'h03, STORE = 7'h23,
                         OPI = 7'h13, OPR = 7'h33, SYS = 7'h73;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [11:0] req_addr = 12'h780;
  logic [63:0] req_data = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [63:0] resp_data;

  always #5 clk = ~clk;

  vscale_sim_top DUT (
    .clk                 (clk),
    .reset               (reset),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { string name; logic [63:0] data; } exp_t;
  exp_t exp_q[$];

  typedef struct { string name; logic [31:0] a, b, instr, exp; } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int f7, int s2, int s1, int f3, int d, int op);
    logic [31:0] a = f7, b = s2, c = s1, e = f3, g = d, h = op;
    return {a[6:0], b[4:0], c[4:0], e[2:0], g[4:0], h[6:0]};
  endfunction
  function automatic logic [31:0] enc_i(int imm, int s1, int f3, int d, int op);
    logic [31:0] v = imm, c = s1, e = f3, g = d, h = op;
    return {v[11:0], c[4:0], e[2:0], g[4:0], h[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int s2, int s1, int f3);
    logic [31:0] v = imm, b = s2, c = s1, e = f3;
    return {v[11:5], b[4:0], c[4:0], e[2:0], v[4:0], STORE};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int s2, int s1, int f3);
    logic [31:0] v = imm, b = s2, c = s1, e = f3;
    return {v[12], v[10:5], b[4:0], c[4:0], e[2:0], v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int d, int op);
    logic [31:0] v = imm, g = d, h = op;
    return {v[19:0], g[4:0], h[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int d);
    logic [31:0] v = imm, g = d;
    return {v[20], v[10:1], v[11], v[19:12], g[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] csrw_tohost(int s1);
    return enc_i(32'h780, s1, 1, 0, SYS);
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    DUT.hasti_mem.mem[128 + idx] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic htif_send(input logic rw, input logic [63:0] data, input string name,
                           input logic [63:0] exp);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({name, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_rw = rw; req_addr = 12'h780; req_data = data;
    @(posedge clk);
    exp_q.push_back('{name, exp});
    #1 req_valid = 1'b0;
  endtask

  task automatic htif_recv();
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd0, {32'd0, resp_data[31:0]} | 64'h1);
      return;
    end
    e = exp_q.pop_front();
    check({e.name, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
    check({e.name, "_busy"}, {63'd0, req_ready}, 64'd0);
    check(e.name, resp_data, e.data);
  endtask

  task automatic htif_read(input string name, input logic [63:0] exp);
    htif_send(1'b0, 64'd0, name, exp);
    htif_recv();
  endtask

  task automatic htif_write(input logic [63:0] data);
    htif_send(1'b1, data, "htif_wr", 64'd0);
    htif_recv();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{"add",     32'd7,          32'd5,          enc_r(0, 2, 1, 0, 3, OPR),    32'd12});
    vecs.push_back('{"add_wrap",32'hFFFFFFFF,   32'd2,          enc_r(0, 2, 1, 0, 3, OPR),    32'd1});
    vecs.push_back('{"sub",     32'd5,          32'd7,          enc_r(32, 2, 1, 0, 3, OPR),   32'hFFFFFFFE});
    vecs.push_back('{"sll_5bit",32'd1,          32'd33,         enc_r(0, 2, 1, 1, 3, OPR),    32'd2});
    vecs.push_back('{"sra",     32'h80000000,   32'd4,          enc_r(32, 2, 1, 5, 3, OPR),   32'hF8000000});
    vecs.push_back('{"srl",     32'h80000000,   32'd4,          enc_r(0, 2, 1, 5, 3, OPR),    32'h08000000});
    vecs.push_back('{"slt",     32'hFFFFFFFF,   32'd1,          enc_r(0, 2, 1, 2, 3, OPR),    32'd1});
    vecs.push_back('{"sltu",    32'hFFFFFFFF,   32'd1,          enc_r(0, 2, 1, 3, 3, OPR),    32'd0});
    vecs.push_back('{"xor",     32'hF0F0F0F0,   32'hFF00FF00,   enc_r(0, 2, 1, 4, 3, OPR),    32'h0FF00FF0});
    vecs.push_back('{"or",      32'hF0F0F0F0,   32'hFF00FF00,   enc_r(0, 2, 1, 6, 3, OPR),    32'hFFF0FFF0});
    vecs.push_back('{"and",     32'hF0F0F0F0,   32'hFF00FF00,   enc_r(0, 2, 1, 7, 3, OPR),    32'hF000F000});
    vecs.push_back('{"addi_neg",32'd0,          32'd0,          enc_i(-1, 1, 0, 3, OPI),      32'hFFFFFFFF});
    vecs.push_back('{"srai31",  32'h80000000,   32'd0,          enc_i(32'h41F, 1, 5, 3, OPI), 32'hFFFFFFFF});
    vecs.push_back('{"sltiu",   32'd5,          32'd0,          enc_i(-1, 1, 3, 3, OPI),      32'd1});
    vecs.push_back('{"lui",     32'd0,          32'd0,          enc_u(32'h12345, 3, LUI),     32'h12345000});
    vecs.push_back('{"auipc",   32'd0,          32'd0,          enc_u(1, 3, AUIPC),           32'h00001208});
    vecs.push_back('{"jal_link",32'd0,          32'd0,          enc_j(4, 3),                  32'h0000020C});
    vecs.push_back('{"jalr",    32'd0,          32'h20C,        enc_i(1, 2, 0, 3, 7'h67),     32'h0000020C});

    // Reset state, sampled while reset is still held.
    repeat (2) @(negedge clk);
    check("rst_req_ready",  {63'd0, req_ready},  64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_data",  resp_data,           64'd0);
    check("rst_pc",         {32'd0, DUT.pc},     64'h200);
    reset = 1'b1;

    // Vector table: lw x1; lw x2; <op x3>; csrw tohost,x3; j .
    for (int i = 0; i < vecs.size(); i++) begin
      DUT.hasti_mem.mem[64] = vecs[i].a;
      DUT.hasti_mem.mem[65] = vecs[i].b;
      put(0, enc_i(32'h100, 0, 2, 1, LOAD));
      put(1, enc_i(32'h104, 0, 2, 2, LOAD));
      put(2, vecs[i].instr);
      put(3, csrw_tohost(3));
      put(4, enc_j(0, 0));
      do_reset();
      repeat (14) @(posedge clk);
      htif_read(vecs[i].name, {32'd0, vecs[i].exp});
    end

    // First-program scenario: addi x1,x0,1; csrw tohost,x1; j .
    put(0, enc_i(1, 0, 0, 1, OPI)); put(1, csrw_tohost(1)); put(2, enc_j(0, 0));
    do_reset();
    repeat (14) @(posedge clk);
    htif_read("hello_tohost", 64'd1);

    // Same-cycle collision: HTIF write accepted on the csrw execute edge wins.
    do_reset();
    repeat (3) @(posedge clk);
    #1 req_valid = 1'b1; req_rw = 1'b1; req_addr = 12'h780; req_data = 64'd9;
    @(posedge clk);
    exp_q.push_back('{"collide_wr", 64'd0});
    #1 req_valid = 1'b0;
    htif_recv();
    htif_read("collide_htif_wins", 64'd9);

    // 7+5 through memory at 0x1000, then tohost=(sum<<1)|1.
    DUT.hasti_mem.mem[1024] = 32'd0;
    put(0, enc_i(7, 0, 0, 1, OPI));
    put(1, enc_i(5, 0, 0, 2, OPI));
    put(2, enc_r(0, 2, 1, 0, 3, OPR));
    put(3, enc_u(1, 4, LUI));
    put(4, enc_s(0, 3, 4, 2));
    put(5, enc_i(0, 4, 2, 5, LOAD));
    put(6, enc_i(1, 5, 1, 6, OPI));
    put(7, enc_i(1, 6, 6, 6, OPI));
    put(8, csrw_tohost(6));
    put(9, enc_j(0, 0));
    do_reset();
    repeat (24) @(posedge clk);
    htif_read("sum_tohost", 64'd25);
    check("sum_mem_0x1000", {32'd0, DUT.hasti_mem.mem[1024]}, 64'd12);

    // x0 writes ignored, CSR old values, unimplemented CSR, immediate CSR ops.
    put(0, enc_i(5, 0, 0, 0, OPI));
    put(1, enc_i(3, 0, 0, 1, OPI));
    put(2, csrw_tohost(1));
    put(3, enc_i(32'h780, 0, 2, 4, SYS));
    put(4, enc_r(0, 0, 4, 0, 5, OPR));
    put(5, enc_i(4, 5, 1, 5, OPI));
    put(6, enc_i(32'h781, 5, 5, 6, SYS));
    put(7, enc_r(0, 6, 5, 0, 5, OPR));
    put(8, csrw_tohost(5));
    put(9, enc_i(32'h780, 16, 7, 0, SYS));
    put(10, enc_i(32'h780, 1, 6, 7, SYS));
    put(11, enc_r(0, 7, 7, 0, 8, OPR));
    put(12, enc_i(32'h780, 8, 2, 0, SYS));
    put(13, enc_j(0, 0));
    do_reset();
    repeat (34) @(posedge clk);
    htif_read("csr_x0_mix", 64'h61);

    // BLTU not taken and BLT taken for x1=0xFFFFFFFF, x2=1.
    put(0, enc_i(-1, 0, 0, 1, OPI));
    put(1, enc_i(1, 0, 0, 2, OPI));
    put(2, enc_i(0, 0, 0, 3, OPI));
    put(3, enc_b(8, 2, 1, 6));
    put(4, enc_i(1, 3, 6, 3, OPI));
    put(5, enc_b(8, 2, 1, 4));
    put(6, enc_i(2, 3, 6, 3, OPI));
    put(7, csrw_tohost(3));
    put(8, enc_j(0, 0));
    do_reset();
    repeat (24) @(posedge clk);
    htif_read("bltu_nt_blt_t", 64'd1);

    // Illegal all-zero word halts; halt persists so a later HTIF write sticks.
    put(0, 32'h00000000);
    do_reset();
    repeat (6) @(posedge clk);
    htif_read("illegal_tohost", 64'h0000FFFF);
    check("halt_pc", {32'd0, DUT.pc}, 64'h200);
    htif_write(64'd3);
    repeat (8) @(posedge clk);
    htif_read("halt_sticky", 64'd3);

    put(0, enc_i(2, 0, 2, 1, LOAD));
    do_reset();
    repeat (6) @(posedge clk);
    htif_read("misaligned_lw", 64'h0000FFFF);

    DUT.hasti_mem.mem[0] = 32'hDEADBEEF;
    put(0, enc_s(1, 0, 0, 2));
    do_reset();
    repeat (6) @(posedge clk);
    htif_read("misaligned_sw", 64'h0000FFFF);
    check("misaligned_sw_nowrite", {32'd0, DUT.hasti_mem.mem[0]}, 64'hDEADBEEF);

    // Response held under back-pressure; reads do not clear tohost.
    put(0, enc_j(0, 0));
    do_reset();
    htif_write(64'd5);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 12'h780;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("hold_valid_%0d", c), {63'd0, resp_valid}, 64'd1);
      check($sformatf("hold_data_%0d", c),  resp_data,           64'd5);
      check($sformatf("hold_ready_%0d", c), {63'd0, req_ready},  64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("released_valid", {63'd0, resp_valid}, 64'd0);
    check("released_data",  resp_data,           64'd0);
    check("released_ready", {63'd0, req_ready},  64'd1);
    htif_read("read_keeps_tohost", 64'd5);

    // Mid-program and mid-handshake reset: restart at RESET_PC with tohost cleared.
    put(0, enc_i(1, 1, 0, 1, OPI));
    put(1, csrw_tohost(1));
    put(2, enc_s(32'h40, 1, 0, 2));
    put(3, enc_j(-12, 0));
    do_reset();
    repeat (31) @(posedge clk);
    resp_ready = 1'b0;
    #1 req_valid = 1'b1; req_rw = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    do_reset();
    check("midrst_pc",         {32'd0, DUT.pc},     64'h200);
    check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    resp_ready = 1'b1;
    htif_read("midrst_tohost", 64'd0);
    repeat (4) @(posedge clk);
    htif_read("midrst_restart", 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
